riscv_core_mul_ctrl: RTL and testbench

Operand conditioning and result formatting for the M-extension multiply path. Accepts MUL/MULH/MULHSU/MULHU/MULW from the execute stage. Converts signed operands to magnitudes, drives the unsigned 64-cycle shift-add multiplier (riscv_core_booth) through its en/done interface, and holds its operands stable. On done, applies sign correction and half/word selection, then returns one XLEN result with a single-cycle valid pulse.

---
 rtl/riscv_core_mul_pkg.sv | 31 +++
 rtl/riscv_core_mul_sign_fix.sv | 30 +++
 rtl/riscv_core_mul_ctrl.sv | 171 +++++++++++++++++
 tb/tb_riscv_core_mul_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_mul_pkg.sv
// Shared types and constants for the M-extension multiply controller.
// Optional zero-operand bypass is enabled by defining MUL_ZERO_BYPASS_EN.
package riscv_core_mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'b00,
        MULH   = 2'b01,
        MULHSU = 2'b10,
        MULHU  = 2'b11
    } mul_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } mul_state_e;

    // accept edge to result-valid cycle, through the 64-cycle shift-add unit
    localparam int MUL_LATENCY = 66;

    function automatic logic rs1_is_signed(input mul_op_e op);
        return (op != MULHU);
    endfunction

    function automatic logic rs2_is_signed(input mul_op_e op);
        return (op == MUL) || (op == MULH);
    endfunction

endpackage

// File: rtl/riscv_core_mul_sign_fix.sv
// Result formatting: re-applies the sign to the unsigned product and selects
// the low half, high half or sign-extended low word.
module riscv_core_mul_sign_fix
    import riscv_core_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2*XLEN-1:0] product,
    input  logic              negate,
    input  mul_op_e           op,
    input  logic              word,
    output logic [XLEN-1:0]   result
);

    logic [2*XLEN-1:0] prod_fix;

    always_comb begin
        prod_fix = negate ? -product : product;
        result   = '0;
        if (word) begin
            result = {{(XLEN-32){prod_fix[31]}}, prod_fix[31:0]};
        end else begin
            case (op)
                MUL:     result = prod_fix[XLEN-1:0];
                default: result = prod_fix[2*XLEN-1:XLEN];
            endcase
        end
    end

endmodule

// File: rtl/riscv_core_mul_ctrl.sv
// Multiply controller: operand conditioning, riscv_core_booth handshake, result
// formatting. Build option MUL_ZERO_BYPASS_EN short-cuts zero operands to RESP.
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_START | one-cycle start pulse to the multiplier
//   ST_WAIT  | multiplier busy, waiting for done
//   ST_RESP  | one-cycle result pulse
//   ST_DRAIN | flushed op still running in the multiplier, product discarded
module riscv_core_mul_ctrl
    import riscv_core_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic              i_booth_clk,
    input  logic              i_booth_rstn,
    input  logic              i_mul_valid,
    output logic              o_mul_ready,
    input  logic [1:0]        i_mul_op,
    input  logic              i_mul_word,
    input  logic [XLEN-1:0]   i_mul_rs1,
    input  logic [XLEN-1:0]   i_mul_rs2,
    input  logic              i_mul_flush,
    output logic [XLEN-1:0]   o_mul_result,
    output logic              o_mul_result_valid,
    output logic              o_booth_en,
    output logic [XLEN-1:0]   o_booth_multiplicand,
    output logic [XLEN-1:0]   o_booth_multiplier,
    input  logic              i_booth_done,
    input  logic [2*XLEN-1:0] i_booth_product
);

    mul_state_e      state;
    mul_op_e         op_q;
    logic            word_q;
    logic            neg_q;
    logic            ready_q;
    logic            resp_q;
    logic            booth_en_q;
    logic [XLEN-1:0] mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [XLEN-1:0] result_q;

    mul_op_e         op_in;
    logic [XLEN-1:0] rs1_eff;
    logic [XLEN-1:0] rs2_eff;
    logic [XLEN-1:0] mag1;
    logic [XLEN-1:0] mag2;
    logic            sgn1;
    logic            sgn2;
    logic            neg_d;
    logic [XLEN-1:0] fix_result;

    always_comb begin
        op_in   = mul_op_e'(i_mul_op);
        rs1_eff = i_mul_rs1;
        rs2_eff = i_mul_rs2;
        sgn1    = 1'b0;
        sgn2    = 1'b0;
        if (i_mul_word) begin
            rs1_eff = {{(XLEN-32){1'b0}}, i_mul_rs1[31:0]};
            rs2_eff = {{(XLEN-32){1'b0}}, i_mul_rs2[31:0]};
        end else begin
            sgn1 = rs1_is_signed(op_in) && i_mul_rs1[XLEN-1];
            sgn2 = rs2_is_signed(op_in) && i_mul_rs2[XLEN-1];
        end
        // the most negative value maps onto itself, which is its correct unsigned magnitude
        mag1  = sgn1 ? -rs1_eff : rs1_eff;
        mag2  = sgn2 ? -rs2_eff : rs2_eff;
        neg_d = sgn1 ^ sgn2;
    end

`ifdef MUL_ZERO_BYPASS_EN
    logic zero_op;
    assign zero_op = (rs1_eff == '0) || (rs2_eff == '0);
`endif

    riscv_core_mul_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .product (i_booth_product),
        .negate  (neg_q),
        .op      (op_q),
        .word    (word_q),
        .result  (fix_result)
    );

    assign o_mul_ready          = ready_q && !i_mul_flush;
    assign o_mul_result_valid   = resp_q && !i_mul_flush;
    assign o_mul_result         = result_q;
    assign o_booth_en           = booth_en_q;
    assign o_booth_multiplicand = mcand_q;
    assign o_booth_multiplier   = mplier_q;

    always_ff @(posedge i_booth_clk or negedge i_booth_rstn) begin
        if (!i_booth_rstn) begin
            state      <= ST_IDLE;
            op_q       <= MUL;
            word_q     <= 1'b0;
            neg_q      <= 1'b0;
            ready_q    <= 1'b0;
            resp_q     <= 1'b0;
            booth_en_q <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            result_q   <= '0;
        end else begin
            booth_en_q <= 1'b0;
            resp_q     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    if (i_mul_valid && o_mul_ready) begin
                        op_q     <= op_in;
                        word_q   <= i_mul_word;
                        neg_q    <= neg_d;
                        mcand_q  <= mag1;
                        mplier_q <= mag2;
                        ready_q  <= 1'b0;
`ifdef MUL_ZERO_BYPASS_EN
                        if (zero_op) begin
                            state    <= ST_RESP;
                            resp_q   <= 1'b1;
                            result_q <= '0;
                        end else begin
                            state      <= ST_START;
                            booth_en_q <= 1'b1;
                        end
`else
                        state      <= ST_START;
                        booth_en_q <= 1'b1;
`endif
                    end
                end
                // the start pulse is already out, so a flush here must still drain
                ST_START: begin
                    state <= i_mul_flush ? ST_DRAIN : ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_mul_flush) begin
                        if (i_booth_done) begin
                            state   <= ST_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (i_booth_done) begin
                        state    <= ST_RESP;
                        resp_q   <= 1'b1;
                        result_q <= fix_result;
                    end
                end
                ST_RESP: begin
                    state    <= ST_IDLE;
                    ready_q  <= 1'b1;
                    result_q <= '0;
                end
                ST_DRAIN: begin
                    if (i_booth_done) begin
                        state   <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_core_mul_ctrl.sv
// Bench for riscv_core_mul_ctrl with a behavioural 64-cycle multiplier model.
// Expectations follow MUL_ZERO_BYPASS_EN when it is defined.
module tb_riscv_core_mul_ctrl;
    import riscv_core_mul_pkg::*;

`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          mul_valid;
    logic          mul_ready;
    logic [1:0]    mul_op;
    logic          mul_word;
    logic [63:0]   rs1;
    logic [63:0]   rs2;
    logic          flush;
    logic [63:0]   result;
    logic          result_valid;
    logic          booth_en;
    logic [63:0]   mcand;
    logic [63:0]   mplier;
    logic          booth_done;
    logic [127:0]  booth_product;

    riscv_core_mul_ctrl #(.XLEN(64)) dut (
        .i_booth_clk          (clk),
        .i_booth_rstn         (rstn),
        .i_mul_valid          (mul_valid),
        .o_mul_ready          (mul_ready),
        .i_mul_op             (mul_op),
        .i_mul_word           (mul_word),
        .i_mul_rs1            (rs1),
        .i_mul_rs2            (rs2),
        .i_mul_flush          (flush),
        .o_mul_result         (result),
        .o_mul_result_valid   (result_valid),
        .o_booth_en           (booth_en),
        .o_booth_multiplicand (mcand),
        .o_booth_multiplier   (mplier),
        .i_booth_done         (booth_done),
        .i_booth_product      (booth_product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // multiplier model: done 64 cycles after the start pulse, no abort
    logic [6:0]  bcnt;
    logic [63:0] cap_a;
    logic [63:0] cap_b;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bcnt  <= '0;
            cap_a <= '0;
            cap_b <= '0;
        end else if (booth_en) begin
            bcnt  <= 7'd64;
            cap_a <= mcand;
            cap_b <= mplier;
        end else if (bcnt != 0) begin
            bcnt <= bcnt - 7'd1;
        end
    end
    assign booth_done    = (bcnt == 7'd1);
    assign booth_product = {64'd0, mcand} * {64'd0, mplier};

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_cnt = 0;
    int en_cyc = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    int acc_cyc = 0;
    int en0 = 0;
    logic [63:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        if (word) begin
            p = {96'd0, a[31:0]} * {96'd0, b[31:0]};
            return {{32{p[31]}}, p[31:0]};
        end
        ea = (op == 2'b11) ? {64'd0, a} : {{64{a[63]}}, a};
        eb = (op == 2'b00 || op == 2'b01) ? {{64{b[63]}}, b} : {64'd0, b};
        p  = ea * eb;
        return (op == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    always @(negedge clk) begin
        if (booth_en) begin
            en_cnt++;
            en_cyc = cyc;
        end
        if (booth_done) begin
            check("booth_multiplicand_stable", mcand, cap_a);
            check("booth_multiplier_stable", mplier, cap_b);
        end
        if (result_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            if (exp_q.size() == 0) check("unexpected_result_valid", 64'd1, 64'd0);
            else                   check("result", result, exp_q.pop_front());
        end
    end

    // called at a negedge; returns at the negedge of T+1
    task automatic issue(input logic [1:0] op, input logic word, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        while (!mul_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("issue_ready", 64'(mul_ready), 64'd1);
        mul_op    = op;
        mul_word  = word;
        rs1       = a;
        rs2       = b;
        mul_valid = 1'b1;
        acc_cyc   = cyc;
        en0       = en_cnt;
        @(negedge clk);
        mul_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    task automatic do_op(input vec_t v, input string name);
        int   v0;
        int   lat;
        int   n;
        logic z;
        z   = v.word ? (v.a[31:0] == 0 || v.b[31:0] == 0) : (v.a == 0 || v.b == 0);
        lat = (BYPASS && z) ? 1 : MUL_LATENCY;
        v0  = valid_cnt;
        exp_q.push_back(v.exp);
        issue(v.op, v.word, v.a, v.b);
        n = 0;
        while (valid_cnt == v0 && n < 150) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, 64'(valid_cyc - acc_cyc), 64'(lat));
        check({name, "_booth_en_pulses"}, 64'(en_cnt - en0), (lat == 1) ? 64'd0 : 64'd1);
        if (lat != 1) check({name, "_booth_en_cycle"}, 64'(en_cyc - acc_cyc), 64'd1);
    endtask

    localparam int NV = 19;
    vec_t vecs[NV];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   v0;
        int   bad;
        int   acc_prev;

        vecs[0]  = '{2'b00, 1'b0, 64'd7,                   64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[1]  = '{2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[2]  = '{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        vecs[3]  = '{2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
        vecs[4]  = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,                   64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5]  = '{2'b10, 1'b0, 64'd2,                   64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        vecs[6]  = '{2'b00, 1'b1, 64'h0000_0000_4000_0000, 64'd2,                   64'hFFFF_FFFF_8000_0000};
        vecs[7]  = '{2'b00, 1'b1, 64'h1234_5678_0000_0003, 64'hFFFF_FFFF_0000_0005, 64'hF};
        vecs[8]  = '{2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        vecs[9]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
        vecs[10] = '{2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'd1,                   64'hFFFF_FFFF_FFFF_FFFF};
        vecs[11] = '{2'b11, 1'b0, 64'h1234,                64'd0,                   64'h0};
        vecs[12] = '{2'b00, 1'b1, 64'd5,                   64'hFFFF_FFFF_0000_0000, 64'h0};
        for (int i = 13; i < NV; i++) begin
            vecs[i].op   = 2'($urandom_range(0, 3));
            vecs[i].word = ($urandom_range(0, 3) == 0);
            vecs[i].a    = {$urandom, $urandom};
            vecs[i].b    = {$urandom, $urandom};
            vecs[i].exp  = ref_mul(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b);
        end

        rstn = 1'b1; mul_valid = 1'b0; mul_op = 2'b00; mul_word = 1'b0;
        rs1 = '0; rs2 = '0; flush = 1'b0;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 64'(mul_ready), 64'd0);
        check("reset_valid", 64'(result_valid), 64'd0);
        check("reset_booth_en", 64'(booth_en), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_multiplicand", mcand, 64'd0);
        check("reset_multiplier", mplier, 64'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 64'(mul_ready), 64'd1);

        for (int i = 0; i < NV; i++) do_op(vecs[i], $sformatf("vec%0d", i));

        // flush while WAIT, mid-operation
        v0 = valid_cnt;
        issue(2'b00, 1'b0, 64'd5, 64'd6);
        while (cyc < acc_cyc + 10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        bad = 0;
        while (cyc < acc_cyc + MUL_LATENCY) begin
            if (mul_ready) bad++;
            @(negedge clk);
        end
        check("flush_ready_low_cycles", 64'(bad), 64'd0);
        check("flush_ready_at_T66", 64'(mul_ready), 64'd1);
        check("flush_no_valid", 64'(valid_cnt - v0), 64'd0);
        acc_prev = acc_cyc;
        do_op('{2'b00, 1'b0, 64'd3, 64'd4, 64'd12}, "after_flush");
        check("after_flush_accept_cycle", 64'(acc_cyc - acc_prev), 64'(MUL_LATENCY));

        // flush in the same cycle as done
        v0 = valid_cnt;
        issue(2'b00, 1'b0, 64'd7, 64'd9);
        while (cyc < acc_cyc + MUL_LATENCY - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_on_done_ready", 64'(mul_ready), 64'd1);
        check("flush_on_done_no_valid", 64'(valid_cnt - v0), 64'd0);

        // asynchronous reset mid-operation
        @(negedge clk);
        v0 = valid_cnt;
        issue(2'b11, 1'b0, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888);
        while (cyc < acc_cyc + 30) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("midreset_ready", 64'(mul_ready), 64'd0);
        check("midreset_valid", 64'(result_valid), 64'd0);
        check("midreset_booth_en", 64'(booth_en), 64'd0);
        check("midreset_result", result, 64'd0);
        check("midreset_multiplicand", mcand, 64'd0);
        check("midreset_multiplier", mplier, 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("midreset_ready_after_release", 64'(mul_ready), 64'd1);
        repeat (70) @(negedge clk);
        check("midreset_no_valid", 64'(valid_cnt - v0), 64'd0);
        do_op('{2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFF0, 64'd16, 64'hFFFF_FFFF_FFFF_FFFF}, "after_reset");
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
